mmu_softswitches: RTL and testbench

- Apple IIe MMU/IOU soft-switch register block. Decodes CPU accesses to $C000-$C01F and $C050-$C05F.
- Holds the memory-mapping and display mode latches: PAGE2, HIRES, RAMRD, RAMWRT, STORE80 and ALTZP feed the language-card/aux-RAM mapper directly downstream.
- Returns the $C011-$C01F status bit (D7) to the CPU data mux.

---
 rtl/mmu_softswitches.sv | 119 +++++++++++
 tb/tb_mmu_softswitches.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_softswitches.sv
// Apple IIe MMU/IOU soft-switch block: decodes $C000-$C01F and $C050-$C05F,
// holds the memory-mapping/display latches and returns the D7 status bit.
module mmu_softswitches #(
    parameter logic       TEXT_RST = 1'b1,
    parameter logic [7:0] IO_PAGE  = 8'hC0
) (
    input  logic        mclk28,
    input  logic        reset_in_n,
    input  logic        cpu_en,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic        lc_bank1,
    input  logic        lc_read_en,
    input  logic        vbl,
    output logic        STORE80,
    output logic        RAMRD,
    output logic        RAMWRT,
    output logic        INTCXROM,
    output logic        ALTZP,
    output logic        SLOTC3ROM,
    output logic        COL80,
    output logic        ALTCHAR,
    output logic        TEXT,
    output logic        MIXED,
    output logic        PAGE2,
    output logic        HIRES,
    output logic [3:0]  an,
    output logic        status_oe,
    output logic        status_d7,
    output logic        kbd_clr
);

    // Switch pairs in address order: bit n is controlled by $C0(2n)/$C0(2n+1).
    logic [7:0] mem_q;   // STORE80 RAMRD RAMWRT INTCXROM ALTZP SLOTC3ROM COL80 ALTCHAR
    logic [3:0] disp_q;  // TEXT MIXED PAGE2 HIRES
    logic [3:0] an_q;

    logic [7:0] lo;
    logic       acc;
    logic       in_mem_wr;
    logic       in_disp;
    logic       in_status;
    logic       stat_rd;
    logic       kbd_hit;
    logic       stat_bit;

    assign lo        = addr[7:0];
    assign acc       = cpu_en && (addr[15:8] == IO_PAGE);
    assign in_mem_wr = acc && we && (lo[7:4] == 4'h0);
    assign in_disp   = acc && (lo[7:4] == 4'h5);
    assign in_status = (lo[7:4] == 4'h1) && (lo[3:0] != 4'h0);
    assign stat_rd   = acc && !we && in_status;
    assign kbd_hit   = acc && ((lo == 8'h10) || (we && in_status));

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        stat_bit = 1'b0;
        unique case (lo[3:0])
            4'h1:    stat_bit = ~lc_bank1;
            4'h2:    stat_bit = lc_read_en;
            4'h3:    stat_bit = mem_q[1];
            4'h4:    stat_bit = mem_q[2];
            4'h5:    stat_bit = mem_q[3];
            4'h6:    stat_bit = mem_q[4];
            4'h7:    stat_bit = mem_q[5];
            4'h8:    stat_bit = mem_q[0];
            4'h9:    stat_bit = ~vbl;
            4'hA:    stat_bit = disp_q[0];
            4'hB:    stat_bit = disp_q[1];
            4'hC:    stat_bit = disp_q[2];
            4'hD:    stat_bit = disp_q[3];
            4'hE:    stat_bit = mem_q[7];
            4'hF:    stat_bit = mem_q[6];
            default: stat_bit = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so the status mux
    // above always sees the pre-edge latch values.
    always_ff @(posedge mclk28 or negedge reset_in_n) begin
        if (!reset_in_n) begin
            mem_q     <= '0;
            disp_q    <= {3'b000, TEXT_RST};
            an_q      <= '0;
            status_oe <= 1'b0;
            status_d7 <= 1'b0;
            kbd_clr   <= 1'b0;
        end else begin
            kbd_clr <= kbd_hit;
            if (cpu_en) begin
                status_oe <= stat_rd;
                status_d7 <= stat_rd && stat_bit;
            end
            if (in_mem_wr)
                mem_q[lo[3:1]] <= lo[0];
            if (in_disp) begin
                if (!lo[3])
                    disp_q[lo[2:1]] <= lo[0];
                else
                    an_q[lo[2:1]] <= lo[0];
            end
        end
    end

    assign STORE80   = mem_q[0];
    assign RAMRD     = mem_q[1];
    assign RAMWRT    = mem_q[2];
    assign INTCXROM  = mem_q[3];
    assign ALTZP     = mem_q[4];
    assign SLOTC3ROM = mem_q[5];
    assign COL80     = mem_q[6];
    assign ALTCHAR   = mem_q[7];
    assign TEXT      = disp_q[0];
    assign MIXED     = disp_q[1];
    assign PAGE2     = disp_q[2];
    assign HIRES     = disp_q[3];
    assign an        = an_q;

endmodule

// File: tb/tb_mmu_softswitches.sv
// Self-checking bench for mmu_softswitches: directed vector table, hand-written
// reset sequences and randomized accesses against a behavioural model.
module tb_mmu_softswitches;

    logic        mclk28;
    logic        reset_in_n;
    logic        cpu_en;
    logic [15:0] addr;
    logic        we;
    logic        lc_bank1;
    logic        lc_read_en;
    logic        vbl;
    logic        STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR;
    logic        TEXT, MIXED, PAGE2, HIRES;
    logic [3:0]  an;
    logic        status_oe, status_d7, kbd_clr;

    mmu_softswitches #(.TEXT_RST(1'b1), .IO_PAGE(8'hC0)) dut (
        .mclk28(mclk28), .reset_in_n(reset_in_n), .cpu_en(cpu_en), .addr(addr),
        .we(we), .lc_bank1(lc_bank1), .lc_read_en(lc_read_en), .vbl(vbl),
        .STORE80(STORE80), .RAMRD(RAMRD), .RAMWRT(RAMWRT), .INTCXROM(INTCXROM),
        .ALTZP(ALTZP), .SLOTC3ROM(SLOTC3ROM), .COL80(COL80), .ALTCHAR(ALTCHAR),
        .TEXT(TEXT), .MIXED(MIXED), .PAGE2(PAGE2), .HIRES(HIRES), .an(an),
        .status_oe(status_oe), .status_d7(status_d7), .kbd_clr(kbd_clr)
    );

    initial mclk28 = 1'b0;
    always #18 mclk28 = ~mclk28;

    // Observation word bit positions.
    localparam int B_S80 = 18, B_RAMRD = 17, B_RAMWRT = 16, B_ALTZP = 14;
    localparam int B_TEXT = 10, B_PAGE2 = 8, B_HIRES = 7, B_AN0 = 3;
    localparam int B_OE = 2, B_D7 = 1, B_KBD = 0;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [18:0] observe();
        return {STORE80, RAMRD, RAMWRT, INTCXROM, ALTZP, SLOTC3ROM, COL80, ALTCHAR,
                TEXT, MIXED, PAGE2, HIRES, an, status_oe, status_d7, kbd_clr};
    endfunction

    // ---------------- behavioural model ----------------
    // sw[n] is the latch toggled by writes to $C000+2n (clear) / $C000+2n+1 (set).
    logic m_sw[8];
    logic m_disp[4];   // TEXT, MIXED, PAGE2, HIRES
    logic m_an[4];
    logic m_oe, m_d7, m_kbd;

    function automatic void model_reset();
        foreach (m_sw[i]) m_sw[i] = 1'b0;
        foreach (m_disp[i]) m_disp[i] = 1'b0;
        foreach (m_an[i]) m_an[i] = 1'b0;
        m_disp[0] = 1'b1;
        m_oe = 1'b0; m_d7 = 1'b0; m_kbd = 1'b0;
    endfunction

    function automatic logic model_status(input int off, input logic b1, input logic rd,
                                          input logic vb);
        case (off)
            'h11: return !b1;
            'h12: return rd;
            'h13: return m_sw[1];
            'h14: return m_sw[2];
            'h15: return m_sw[3];
            'h16: return m_sw[4];
            'h17: return m_sw[5];
            'h18: return m_sw[0];
            'h19: return !vb;
            'h1A: return m_disp[0];
            'h1B: return m_disp[1];
            'h1C: return m_disp[2];
            'h1D: return m_disp[3];
            'h1E: return m_sw[7];
            'h1F: return m_sw[6];
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_step(input logic en, input logic [15:0] a, input logic w,
                                       input logic b1, input logic rd, input logic vb);
        int  off;
        bit  io;
        bit  st;
        off = int'(a[7:0]);
        io  = en && (a[15:8] == 8'hC0);
        st  = io && !w && off >= 'h11 && off <= 'h1F;
        m_kbd = io && (off == 'h10 || (w && off >= 'h11 && off <= 'h1F));
        if (en) begin
            m_d7 = st ? model_status(off, b1, rd, vb) : 1'b0;
            m_oe = st;
        end
        if (io && w && off <= 'h0F)
            m_sw[off / 2] = off[0];
        if (io && off >= 'h50 && off <= 'h57)
            m_disp[(off - 'h50) / 2] = off[0];
        if (io && off >= 'h58 && off <= 'h5F)
            m_an[(off - 'h58) / 2] = off[0];
    endfunction

    function automatic logic [18:0] model_word();
        return {m_sw[0], m_sw[1], m_sw[2], m_sw[3], m_sw[4], m_sw[5], m_sw[6], m_sw[7],
                m_disp[0], m_disp[1], m_disp[2], m_disp[3],
                m_an[3], m_an[2], m_an[1], m_an[0], m_oe, m_d7, m_kbd};
    endfunction

    // One clock: drive at a falling edge, let the rising edge sample, compare at
    // the next falling edge.
    task automatic cycle(input string name, input logic en, input logic [15:0] a,
                         input logic w, input logic b1, input logic rd, input logic vb);
        cpu_en = en; addr = a; we = w; lc_bank1 = b1; lc_read_en = rd; vbl = vb;
        model_step(en, a, w, b1, rd, vb);
        @(negedge mclk28);
        check(name, observe(), model_word());
    endtask

    task automatic idle();
        cycle("idle", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        en;
        logic [15:0] a;
        logic        w;
        logic        b1;
        logic        vb;
        logic [18:0] mask;
        logic [18:0] val;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [18:0] bm(input int pos);
        logic [18:0] m;
        m = '0;
        m[pos] = 1'b1;
        return m;
    endfunction

    function automatic void add(input string nm, input logic en, input logic [15:0] a,
                                input logic w, input logic b1, input logic vb,
                                input logic [18:0] mask, input logic [18:0] val);
        vec_t v;
        v.name = nm; v.en = en; v.a = a; v.w = w; v.b1 = b1; v.vb = vb;
        v.mask = mask; v.val = val;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [18:0] rst_word;
        reset_in_n = 1'b0;
        cpu_en = 1'b0; addr = '0; we = 1'b0;
        lc_bank1 = 1'b0; lc_read_en = 1'b0; vbl = 1'b0;
        model_reset();
        rst_word = 19'h0 | bm(B_TEXT);

        // Reset held while cpu_en toggles on a STORE80 set write.
        repeat (2) @(negedge mclk28);
        for (int i = 0; i < 4; i++) begin
            cpu_en = (i % 2 == 0); addr = 16'hC001; we = 1'b1;
            @(negedge mclk28);
            check("reset_hold", observe(), rst_word);
        end
        cpu_en = 1'b0;
        reset_in_n = 1'b1;
        idle();
        check("reset_release", observe(), rst_word);

        add("set_store80",  1, 16'hC001, 1, 0, 0, bm(B_S80),               bm(B_S80));
        add("set_page2",    1, 16'hC055, 0, 0, 0, bm(B_PAGE2),             bm(B_PAGE2));
        add("set_hires",    1, 16'hC057, 0, 0, 0, bm(B_HIRES),             bm(B_HIRES));
        add("clr_store80",  1, 16'hC000, 1, 0, 0, bm(B_S80) | bm(B_PAGE2), bm(B_PAGE2));
        add("rd_c003",      1, 16'hC003, 0, 0, 0, bm(B_RAMRD),             19'h0);
        add("rd_c009",      1, 16'hC009, 0, 0, 0, bm(B_ALTZP),             19'h0);
        add("no_en_c003",   0, 16'hC003, 1, 0, 0, bm(B_RAMRD),             19'h0);
        add("set_ramwrt",   1, 16'hC005, 1, 0, 0, bm(B_RAMWRT),            bm(B_RAMWRT));
        add("stat_c014",    1, 16'hC014, 0, 0, 0, bm(B_OE) | bm(B_D7),     bm(B_OE) | bm(B_D7));
        add("stat_hold",    0, 16'hC000, 0, 0, 0, bm(B_OE) | bm(B_D7),     bm(B_OE) | bm(B_D7));
        add("stat_bank1",   1, 16'hC011, 0, 1, 0, bm(B_OE) | bm(B_D7),     bm(B_OE));
        add("stat_vbl",     1, 16'hC019, 0, 0, 1, bm(B_OE) | bm(B_D7),     bm(B_OE));
        add("kbd_rd_c010",  1, 16'hC010, 0, 0, 0, bm(B_KBD) | bm(B_OE),    bm(B_KBD));
        add("kbd_one_clk",  0, 16'hC010, 0, 0, 0, bm(B_KBD),               19'h0);
        add("kbd_wr_c018",  1, 16'hC018, 1, 0, 0, bm(B_KBD) | bm(B_S80) | bm(B_OE), bm(B_KBD));
        add("rd_c018",      1, 16'hC018, 0, 0, 0, bm(B_KBD) | bm(B_OE) | bm(B_D7), bm(B_OE));
        add("unlisted_c0ff",1, 16'hC0FF, 0, 0, 0, bm(B_OE) | bm(B_KBD),    19'h0);
        add("other_page",   1, 16'hC114, 0, 0, 0, bm(B_OE),                19'h0);

        foreach (vecs[i]) begin
            cycle("model", vecs[i].en, vecs[i].a, vecs[i].w, vecs[i].b1, 1'b0, vecs[i].vb);
            check(vecs[i].name, observe() & vecs[i].mask, vecs[i].val);
        end
        idle();

        // Mid-operation reset between clock edges.
        cycle("set_ramwrt2", 1, 16'hC005, 1, 0, 0, 0);
        cycle("set_an1",     1, 16'hC05B, 0, 0, 0, 0);
        cycle("set_an3",     1, 16'hC05F, 1, 0, 0, 0);
        cycle("clr_text",    1, 16'hC050, 0, 0, 0, 0);
        idle();
        check("pre_reset_an", observe() & (19'hF << B_AN0), 19'(4'b1010) << B_AN0);
        #5 reset_in_n = 1'b0;
        model_reset();
        #1 check("async_reset", observe(), rst_word);
        #3 reset_in_n = 1'b1;
        @(negedge mclk28);
        check("after_reset", observe(), rst_word);
        cycle("post_rst_an1", 1, 16'hC05B, 0, 0, 0, 0);
        check("an1_set", observe() & (19'hF << B_AN0), 19'(4'b0010) << B_AN0);
        idle();

        // Randomized accesses against the model.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 3)      a = 16'hC000 + 16'($urandom_range(0, 31));
            else if (sel <= 6) a = 16'hC050 + 16'($urandom_range(0, 15));
            else if (sel == 7) a = {8'hC0, 8'($urandom)};
            else if (sel == 8) a = 16'($urandom);
            else               a = 16'hC010;
            cycle("random", 1'($urandom_range(0, 3) != 0), a, 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
